// File: rtl/arm_core_pkg.sv
// arm_core_pkg: shared condition codes, APSR bit indices, opcode patterns and ITSTATE mapping
package arm_core_pkg;
  typedef enum logic [3:0] {EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL} cond_e;
  typedef enum int {APSR_Q, APSR_V, APSR_C, APSR_Z, APSR_N} apsr_bit_e;
  localparam logic [31:0] NOP_HINT = 32'hBF00_0000;
  localparam logic [7:0] IT_OPCODE = 8'hBF;
  localparam logic [4:0] PFX_A = 5'b11101;
  localparam logic [4:0] PFX_B = 5'b11110;
  localparam logic [4:0] PFX_C = 5'b11111;
  // Top five bits of a halfword that opens a 32-bit instruction
  function automatic logic is_prefix(input logic [4:0] top);
    is_prefix = top == PFX_A || top == PFX_B || top == PFX_C;
  endfunction
  // ITSTATE[7:2] lives in epsr[6:1], ITSTATE[1:0] in epsr[9:8]
  function automatic logic [31:0] it_to_epsr(input logic [7:0] it);
    it_to_epsr = '0;
    it_to_epsr[6:1] = it[7:2];
    it_to_epsr[9:8] = it[1:0];
  endfunction
endpackage

// File: rtl/arm_if.sv
// arm_if: assembles 16/32-bit Thumb-2 instructions from one halfword per clock
// Ports: clk, rst, inst_hw (fetched halfword) -> valid_inst (assembled word), inst_valid
module arm_if
  import arm_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inst_hw,
  output logic [31:0] valid_inst,
  output logic        inst_valid
);
  logic [15:0] hold;
  logic        pending;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_inst <= '0;
      inst_valid <= 1'b0;
      pending    <= 1'b0;
      hold       <= '0;
    end else if (pending) begin
      valid_inst <= {hold, inst_hw};
      inst_valid <= 1'b1;
      pending    <= 1'b0;
    end else if (is_prefix(inst_hw[15:11])) begin
      hold       <= inst_hw;
      pending    <= 1'b1;
      inst_valid <= 1'b0;
    end else begin
      valid_inst <= {inst_hw, 16'h0000};
      inst_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/arm_pre_dec.sv
// arm_pre_dec: IT detection, condition check against APSR and squash of failing instructions
// Ports: inst_valid, valid_inst, it_cond, in_it_blk, apsr -> is_it, hint_or_exc, cur_cond, inst
module arm_pre_dec
  import arm_core_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_HINT
) (
  input  logic        inst_valid,
  input  logic [31:0] valid_inst,
  input  logic [3:0]  it_cond,
  input  logic        in_it_blk,
  input  logic [4:0]  apsr,
  output logic        is_it,
  output logic        hint_or_exc,
  output logic [3:0]  cur_cond,
  output logic [31:0] inst
);
  logic n, z, c, v, base, pass, unused_q;
  assign {n, z, c, v} = {apsr[APSR_N], apsr[APSR_Z], apsr[APSR_C], apsr[APSR_V]};
  assign unused_q = apsr[APSR_Q];
  assign cur_cond = it_cond;
  // A zero mask means a plain hint (NOP/YIELD/...), not an IT
  assign is_it = inst_valid && valid_inst[31:24] == IT_OPCODE && valid_inst[19:16] != 4'h0;
  always_comb begin
    base = cur_cond[3:1] == 3'd0 ? z :
           cur_cond[3:1] == 3'd1 ? c :
           cur_cond[3:1] == 3'd2 ? n :
           cur_cond[3:1] == 3'd3 ? v :
           cur_cond[3:1] == 3'd4 ? c && !z :
           cur_cond[3:1] == 3'd5 ? n == v :
           cur_cond[3:1] == 3'd6 ? n == v && !z : 1'b1;
    pass = cur_cond[0] && cur_cond != 4'hF ? !base : base;
  end
  assign hint_or_exc = inst_valid && in_it_blk && !is_it && !pass;
  assign inst = !inst_valid ? 32'h0 : hint_or_exc ? NOP_WORD : valid_inst;
endmodule

// File: rtl/xpsr_reg.sv
// xpsr_reg: APSR flags, IPSR and the EPSR copy of ITSTATE with IT-block advance
// Ports: clk, rst, inst_valid, is_it, it_load, apsr_wdata, ipsr_wdata -> apsr, it_cond, in_it_blk
module xpsr_reg
  import arm_core_pkg::*;
#(
  parameter logic [4:0] APSR_INIT = 5'b00000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inst_valid,
  input  logic       is_it,
  input  logic [7:0] it_load,
  input  logic [4:0] apsr_wdata,
  input  logic [8:0] ipsr_wdata,
  output logic [4:0] apsr,
  output logic [3:0] it_cond,
  output logic       in_it_blk
);
  logic [31:0] epsr;
  logic [8:0]  ipsr;
  logic [7:0]  itstate, it_nx;
  logic [4:0]  en_apsr;
  logic        en_ipsr, unused_bits;
  // Write enables belong to execute; they stay idle here unless driven from outside
  assign en_apsr = '0;
  assign en_ipsr = 1'b0;
  assign itstate = {epsr[6:1], epsr[9:8]};
  assign it_cond = itstate[7:4];
  assign in_it_blk = itstate[3:0] != 4'h0;
  assign unused_bits = ^{epsr[31:10], epsr[7], epsr[0], ipsr};
  // An IT seen inside an active block only advances it, like any other instruction
  always_comb
    it_nx = !inst_valid ? itstate :
            is_it && !in_it_blk ? it_load :
            !in_it_blk ? itstate :
            itstate[2:0] == 3'd0 ? 8'h00 : {itstate[7:5], itstate[3:0], 1'b0};
  always_ff @(posedge clk) begin
    if (rst) begin
      epsr <= '0;
      apsr <= APSR_INIT;
      ipsr <= '0;
    end else begin
      epsr <= it_to_epsr(it_nx);
      apsr <= (apsr & ~en_apsr) | (apsr_wdata & en_apsr);
      if (en_ipsr) ipsr <= ipsr_wdata;
    end
  end
endmodule

// File: rtl/arm_core.sv
// arm_core: Thumb-2 front end issuing one 32-bit word per valid cycle with IT-block squashing
// Ports: inst_hw (halfword in), rst, clk -> inst (word to decode, 0 when nothing issued)
module arm_core
  import arm_core_pkg::*;
#(
  parameter logic [4:0]  APSR_INIT = 5'b00000,
  parameter logic [31:0] NOP_WORD  = NOP_HINT
) (
  input  logic [15:0] inst_hw,
  input  logic        rst,
  input  logic        clk,
  output logic [31:0] inst
);
  logic [31:0] valid_inst;
  logic        inst_valid, is_it, in_it_blk, hint_or_exc;
  logic [4:0]  apsr;
  logic [3:0]  it_cond, cur_cond;
  arm_if u_if (
    .clk(clk), .rst(rst), .inst_hw(inst_hw), .valid_inst(valid_inst), .inst_valid(inst_valid)
  );
  arm_pre_dec #(.NOP_WORD(NOP_WORD)) u_pre_dec (
    .inst_valid(inst_valid), .valid_inst(valid_inst), .it_cond(it_cond), .in_it_blk(in_it_blk),
    .apsr(apsr), .is_it(is_it), .hint_or_exc(hint_or_exc), .cur_cond(cur_cond), .inst(inst)
  );
  xpsr_reg #(.APSR_INIT(APSR_INIT)) u_xpsr_reg (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .is_it(is_it), .it_load(valid_inst[23:16]),
    .apsr_wdata(5'b00000), .ipsr_wdata(9'h000), .apsr(apsr), .it_cond(it_cond),
    .in_it_blk(in_it_blk)
  );
endmodule

// File: tb/tb_arm_core.sv
// tb_arm_core: randomized scoreboard bench for arm_core against an architectural IT/fetch model
module tb_arm_core;
  logic        clk, rst;
  logic [15:0] inst_hw;
  logic [31:0] inst;
  typedef struct {logic [31:0] inst; logic hint; logic [3:0] cond;} exp_t;
  exp_t       sb[$];
  logic [3:0] conds[$];
  logic       have_prefix;
  logic [15:0] pre;
  logic [4:0] apsr_m;
  int checks, errors;

  arm_core dut (.inst_hw(inst_hw), .rst(rst), .clk(clk), .inst(inst));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [4:0] f);
    bit n, z, cf, v;
    {n, z, cf, v} = f[4:1];
    case (c)
      4'd0: return z;
      4'd1: return !z;
      4'd2: return cf;
      4'd3: return !cf;
      4'd4: return n;
      4'd5: return !n;
      4'd6: return v;
      4'd7: return !v;
      4'd8: return cf && !z;
      4'd9: return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && n == v;
      4'd13: return z || n != v;
      default: return 1;
    endcase
  endfunction

  // Architectural view: an IT with mask m governs (4 - position of m's lowest set bit) instructions;
  // the first uses firstcond, later ones take firstcond[3:1] with mask bits 3,2,1 as the low bit.
  task automatic issue(input logic [31:0] w);
    exp_t e;
    bit it;
    logic [3:0] fc, m;
    int cnt;
    it = w[31:24] == 8'hBF && w[19:16] != 4'h0;
    if (conds.size() != 0) begin
      e.cond = conds.pop_front();
      e.hint = !it && !cond_ok(e.cond, apsr_m);
    end else begin
      e.cond = 4'h0;
      e.hint = 0;
      if (it) begin
        fc = w[23:20];
        m = w[19:16];
        cnt = m[0] ? 4 : m[1] ? 3 : m[2] ? 2 : 1;
        conds.push_back(fc);
        for (int k = 2; k <= cnt; k++) conds.push_back({fc[3:1], m[5-k]});
      end
    end
    e.inst = e.hint ? 32'hBF00_0000 : w;
    sb.push_back(e);
  endtask

  task automatic send_hw(input logic [15:0] hw);
    @(negedge clk);
    rst = 0;
    inst_hw = hw;
    if (have_prefix) begin
      have_prefix = 0;
      issue({pre, hw});
    end else if (hw[15:11] >= 5'b11101) begin
      have_prefix = 1;
      pre = hw;
    end else issue({hw, 16'h0000});
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      rst = 1;
      inst_hw = 16'($urandom);
    end
    have_prefix = 0;
    conds.delete();
    @(posedge clk);
    #1;
    chk("rst_in_it_blk", {31'h0, dut.u_xpsr_reg.in_it_blk}, 32'h0);
    chk("rst_itstate", {24'h0, dut.u_xpsr_reg.epsr[6:1], dut.u_xpsr_reg.epsr[9:8]}, 32'h0);
    chk("rst_inst_valid", {31'h0, dut.inst_valid}, 32'h0);
  endtask

  task automatic send_rand;
    logic [15:0] hw;
    int k;
    k = $urandom_range(0, 9);
    hw = 16'($urandom);
    if (k < 2) send_hw({8'hBF, hw[7:4], 4'($urandom_range(1, 15))});
    else if (k == 2) begin
      send_hw({5'($urandom_range(29, 31)), hw[10:0]});
      send_hw(16'($urandom));
    end else if (k == 3) send_hw({8'hBF, hw[7:4], 4'h0});
    else begin
      hw[15:11] = 5'($urandom_range(0, 28));
      send_hw(hw);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (dut.inst_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got %h expected no instruction", inst);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("inst", inst, e.inst);
          chk("hint_or_exc", {31'h0, dut.u_pre_dec.hint_or_exc}, {31'h0, e.hint});
          chk("cur_cond", {28'h0, dut.u_pre_dec.cur_cond}, {28'h0, e.cond});
        end
      end else chk("idle_inst", inst, 32'h0);
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1;
    inst_hw = 0;
    have_prefix = 0;
    apsr_m = 5'b00000;
    do_reset(3);
    chk("rst_apsr", {27'h0, dut.u_xpsr_reg.apsr}, 32'h0);
    send_hw(16'h2001);
    send_hw(16'h2102);
    send_hw(16'hF000);
    send_hw(16'hF800);
    send_hw(16'hBF08);
    send_hw(16'h2001);
    send_hw(16'hBF18);
    send_hw(16'h2001);
    send_hw(16'hBF06);
    repeat (3) send_hw(16'h2001);
    send_hw(16'hBF06);
    send_hw(16'h2001);
    do_reset(1);
    send_hw(16'h2001);
    repeat (1500) begin
      if ($urandom_range(0, 99) == 0) do_reset($urandom_range(1, 2));
      send_rand();
    end
    repeat (12) begin
      do_reset(1);
      apsr_m = 5'($urandom);
      force dut.u_xpsr_reg.apsr = apsr_m;
      repeat (100) send_rand();
    end
    release dut.u_xpsr_reg.apsr;
    apsr_m = 5'b00000;
    do_reset(2);
    chk("final_apsr", {27'h0, dut.u_xpsr_reg.apsr}, 32'h0);
    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/arm_core.md
Name: arm_core

Overview:
- Thumb-2 front end for a Cortex-M class core. Accepts one instruction halfword per clock and assembles 16- and 32-bit instructions.
- Tracks IT-block state in the xPSR and flags instructions whose IT condition fails so they are squashed to a hint (NOP).
- Feeds the decode/execute stages with one 32-bit instruction word per valid cycle.

Parameters:
- APSR_INIT, 5'b00000, reset value of APSR flags {N,Z,C,V,Q}.
- NOP_WORD, 32'hBF00_0000, word emitted in place of a squashed instruction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- inst_hw  in  16  instruction halfword fetched this cycle.
- inst  out  32  instruction word issued to decode.
- Positional connection order is (inst_hw, rst, clk, inst).

Behaviour:
- Required hierarchy (bench probes these names):
  - u_if (arm_if): reg valid_inst[31:0].
  - top-level wire inst_valid.
  - u_pre_dec (arm_pre_dec): wires hint_or_exc and cur_cond[3:0].
  - u_xpsr_reg (xpsr_reg): regs apsr[4:0] and epsr[31:0]; wires in_it_blk, en_apsr[4:0] and en_ipsr.
- Fetch (u_if), registered; state = hold[15:0] and pending:
  - Reset: valid_inst=0, inst_valid=0, pending=0.
  - pending=1: valid_inst<={hold,inst_hw}, inst_valid<=1, pending<=0.
  - Else, if inst_hw[15:11] is 11101, 11110 or 11111: hold<=inst_hw, pending<=1, inst_valid<=0.
  - Else: valid_inst<={inst_hw,16'h0000}, inst_valid<=1.
  - Latency: 1 clock after the last halfword of an instruction.
- is_it = inst_valid && valid_inst[31:24]==8'hBF && valid_inst[19:16]!=0. BFx0 (mask 0) is a plain hint and is not an IT.
- ITSTATE[7:0] storage: {epsr[6:1], epsr[9:8]}. All other epsr bits read 0. Reset: ITSTATE=0.
- cur_cond = ITSTATE[7:4]. in_it_blk = (ITSTATE[3:0]!=0).
- ITSTATE update, at the edge ending a cycle with inst_valid=1:
  - is_it && !in_it_blk: ITSTATE<=valid_inst[23:16].
  - Else if in_it_blk: if ITSTATE[2:0]==0 then ITSTATE<=0, else ITSTATE[4:0]<=ITSTATE[4:0]<<1.
  - An IT inside an active block is not reloaded; it advances the state like any other instruction.
- Condition pass, from apsr {N=4, Z=3, C=2, V=1, Q=0}, selected by cur_cond[3:1]:
  - 000: Z.
  - 001: C.
  - 010: N.
  - 011: V.
  - 100: C&!Z.
  - 101: N==V.
  - 110: (N==V)&!Z.
  - 111: true.
  - Invert the result when cur_cond[0]=1 and cur_cond!=4'b1111.
- hint_or_exc = inst_valid && in_it_blk && !is_it && !pass. It is combinational and never 1 for AL conditions.
- inst = !inst_valid ? 32'h0 : (hint_or_exc ? NOP_WORD : valid_inst).
- APSR:
  - Reset: APSR_INIT.
  - Per bit i: if en_apsr[i]==1, apsr[i]<=apsr_wdata[i].
  - apsr_wdata is a reserved xpsr_reg input, tied 0 in this block.
  - en_apsr and en_ipsr have no driver inside arm_core; they are reserved for execute and forced externally.
- IPSR: 9-bit, reset 0, written from ipsr_wdata (tied 0) when en_ipsr=1.
- Reset mid-instruction or mid-IT-block clears pending, inst_valid and ITSTATE in the same edge.

Decomposition:
- Package arm_core_pkg:
  - Condition codes EQ..AL (4'b0000..4'b1110).
  - APSR bit indices N/Z/C/V/Q.
  - NOP_WORD and the 32-bit prefix patterns.
  - ITSTATE bit mapping.
- Sub-modules under arm_core:
  - arm_if as u_if.
  - arm_pre_dec as u_pre_dec (condition check, hint_or_exc).
  - xpsr_reg as u_xpsr_reg.

Test Plan:
- Reset, then halfwords 2001, 2102 -> inst_valid=1 one cycle after each; inst=20010000, then 21020000; hint_or_exc=0.
- F000, F800 -> cycle 1: inst_valid=0, inst=0. Next cycle: inst=F000F800.
- APSR=0; BF08 (IT EQ), 2001 -> ITSTATE=08, cur_cond=0000, hint_or_exc=1, inst=BF000000; then in_it_blk=0.
- APSR=0; BF18 (IT NE), 2001 -> inst=20010000, hint_or_exc=0.
- APSR=0; BF06 (ITTE EQ), then three 2001 -> cur_cond 0000, 0000, 0001; hint_or_exc 1, 1, 0; ITSTATE 06->0C->18->00.
- rst asserted after BF06 and one instruction -> next cycle ITSTATE=0, inst_valid=0; following 2001 issues unconditionally.
